// File: rtl/axi_lite_line_fetch.sv
// axi_lite_line_fetch: AXI4-Lite read master refilling one cache block with BLOCK_WORDS sequential single-beat reads.
module axi_lite_line_fetch #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic                           i_start,
  input  logic [ADDR_WIDTH-1:0]          i_addr,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_error,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic                           o_data_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] o_word_idx,
  output logic [ADDR_WIDTH-1:0]          o_araddr,
  output logic                           o_arvalid,
  input  logic                           i_arready,
  output logic [2:0]                     o_arprot,
  input  logic [DATA_WIDTH-1:0]          i_rdata,
  input  logic [1:0]                     i_rresp,
  input  logic                           i_rvalid,
  output logic                           o_rready
);
  localparam int IW = $clog2(BLOCK_WORDS);
  localparam int BW = $clog2(DATA_WIDTH / 8);
  localparam logic [IW-1:0] LAST = IW'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] MASK = {ADDR_WIDTH{1'b1}} << (IW + BW);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_base;
  logic w_start, w_rhs;
  assign w_start  = r_state == IDLE && i_start;
  assign w_rhs    = r_state == DATA && i_rvalid;
  assign o_busy   = r_state != IDLE;
  assign o_done   = r_state == DONE;
  assign o_arvalid = r_state == ADDR;
  assign o_rready = r_state == DATA;
  assign o_arprot = 3'b000;
  assign o_araddr = r_base + (ADDR_WIDTH'(r_count) << BW);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_start ? ADDR : IDLE;
      ADDR:    w_next = i_arready ? DATA : ADDR;
      DATA:    w_next = !i_rvalid ? DATA : (r_count == LAST) ? DONE : ADDR;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_base       <= '0;
      o_error      <= 1'b0;
      o_data       <= '0;
      o_word_idx   <= '0;
      o_data_valid <= 1'b0;
    end else begin
      r_state      <= w_next;
      o_data_valid <= w_rhs;
      if (w_start) begin
        r_base  <= i_addr & MASK;
        r_count <= '0;
        o_error <= 1'b0;
      end
      if (w_rhs) begin
        o_data     <= i_rdata;
        o_word_idx <= r_count;
        if (i_rresp != 2'b00) o_error <= 1'b1;
        if (r_count != LAST) r_count <= r_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_line_fetch.sv
// tb_axi_lite_line_fetch: table-driven refill vectors on a 16-word instance plus a back-to-back check on a 2-word instance.
module tb_axi_lite_line_fetch;
  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  logic        i_start = 1'b0, i_arready = 1'b0, i_rvalid = 1'b0;
  logic [31:0] i_addr = '0, i_rdata = '0;
  logic [1:0]  i_rresp = '0;
  logic        o_busy, o_done, o_error, o_data_valid, o_arvalid, o_rready;
  logic [31:0] o_data, o_araddr;
  logic [3:0]  o_word_idx;
  logic [2:0]  o_arprot;

  axi_lite_line_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_WORDS(16)) dut (
    .clk(clk), .arstn(arstn), .i_start(i_start), .i_addr(i_addr),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_data(o_data),
    .o_data_valid(o_data_valid), .o_word_idx(o_word_idx), .o_araddr(o_araddr),
    .o_arvalid(o_arvalid), .i_arready(i_arready), .o_arprot(o_arprot),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  logic        s2_start = 1'b0;
  logic [31:0] s2_addr = '0;
  logic        o2_busy, o2_done, o2_error, o2_data_valid, o2_arvalid, o2_rready;
  logic [31:0] o2_data, o2_araddr;
  logic [0:0]  o2_word_idx;
  logic [2:0]  o2_arprot;

  axi_lite_line_fetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_WORDS(2)) dut2 (
    .clk(clk), .arstn(arstn), .i_start(s2_start), .i_addr(s2_addr),
    .o_busy(o2_busy), .o_done(o2_done), .o_error(o2_error), .o_data(o2_data),
    .o_data_valid(o2_data_valid), .o_word_idx(o2_word_idx), .o_araddr(o2_araddr),
    .o_arvalid(o2_arvalid), .i_arready(1'b1), .o_arprot(o2_arprot),
    .i_rdata(32'hC0DE_0000), .i_rresp(2'b00), .i_rvalid(1'b1), .o_rready(o2_rready)
  );

  int n_vec = 0, n_err = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] base;
    int          ar_beat;
    int          ar_wait;
    int          err_beat;
    bit          gaps;
    int          restart_beat;
    int          abort_beat;
  } vec_t;
  vec_t vt[6];

  // Called on a negedge with the DUT idle; drives the AXI slave side and checks every beat.
  task automatic run(input vec_t v);
    int exp_cyc = 1;
    logic exp_err = 1'b0;
    int w, g;
    i_start = 1'b1;
    i_addr = v.addr;
    cyc = 0;
    tick();
    i_start = 1'b0;
    chk("error_cleared", o_error, 0);
    for (int k = 0; k < 16; k++) begin
      w = (k == v.ar_beat) ? v.ar_wait : 0;
      for (int j = 0; j <= w; j++) begin
        chk("arvalid", o_arvalid, 1);
        chk("araddr", o_araddr, v.base + 32'(k * 4));
        chk("rready_in_ar", o_rready, 0);
        if (j > 0) chk("dvalid_quiet_ar", o_data_valid, 0);
        if (j == w) i_arready = 1'b1;
        tick();
        i_arready = 1'b0;
      end
      g = v.gaps ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j <= g; j++) begin
        chk("rready", o_rready, 1);
        chk("arvalid_in_r", o_arvalid, 0);
        chk("dvalid_quiet_r", o_data_valid, 0);
        if (k == v.abort_beat) begin
          arstn = 1'b0;
          #1;
          chk("abort_outputs", {o_busy, o_done, o_error, o_data_valid, o_arvalid, o_rready}, 0);
          chk("abort_data", o_data, 0);
          chk("abort_idx", o_word_idx, 0);
          chk("abort_araddr", o_araddr, 0);
          tick();
          arstn = 1'b1;
          return;
        end
        if (k == v.restart_beat && j == 0) begin
          i_start = 1'b1;
          i_addr = 32'h1234_5678;
        end
        if (j == g) begin
          i_rvalid = 1'b1;
          i_rdata = 32'hA000_0000 + 32'(k);
          i_rresp = (k == v.err_beat) ? 2'b10 : 2'b00;
        end
        tick();
        i_rvalid = 1'b0;
        i_rresp = 2'b00;
        i_start = 1'b0;
      end
      if (k == v.err_beat) exp_err = 1'b1;
      chk("dvalid", o_data_valid, 1);
      chk("data", o_data, 32'hA000_0000 + 32'(k));
      chk("word_idx", o_word_idx, 64'(k));
      chk("error", o_error, exp_err);
      exp_cyc += 2 + w + g;
    end
    chk("done", o_done, 1);
    chk("done_cycle", cyc, exp_cyc);
    chk("busy_at_done", o_busy, 1);
    tick();
    chk("done_single", o_done, 0);
    chk("busy_idle", o_busy, 0);
    chk("error_hold", o_error, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    vt[0] = '{32'h8000_0024, 32'h8000_0000, -1, 0, -1, 1'b0, -1, -1};
    vt[1] = '{32'h0000_107F, 32'h0000_1040,  5, 3, -1, 1'b0, -1, -1};
    vt[2] = '{32'hFFFF_FFC8, 32'hFFFF_FFC0, -1, 0,  7, 1'b1, -1, -1};
    vt[3] = '{32'h0000_0004, 32'h0000_0000, -1, 0, -1, 1'b0,  3, -1};
    vt[4] = '{32'h4000_0100, 32'h4000_0100, -1, 0, -1, 1'b0, -1,  9};
    vt[5] = '{32'h4000_013C, 32'h4000_0100,  2, 1, -1, 1'b1, -1, -1};
    #1;
    chk("reset_outputs", {o_busy, o_done, o_error, o_data_valid, o_arvalid, o_rready}, 0);
    chk("reset_araddr", o_araddr, 0);
    chk("reset_data", o_data, 0);
    chk("reset_idx", o_word_idx, 0);
    chk("arprot", o_arprot, 0);
    tick();
    tick();
    arstn = 1'b1;
    tick();
    chk("idle_no_start", o_busy, 0);
    foreach (vt[i]) run(vt[i]);
    // Two-word block: first refill, then i_start held so it is taken the cycle after o_done.
    s2_start = 1'b1;
    s2_addr = 32'h0000_0104;
    t = 0;
    do begin
      tick();
      t++;
    end while (!o2_done && t < 20);
    chk("done2_a_latency", t, 5);
    chk("data2_a", o2_data, 32'hC0DE_0000);
    chk("idx2_a", o2_word_idx, 1);
    tick();
    chk("busy2_idle_gap", o2_busy, 0);
    t = 0;
    do begin
      tick();
      t++;
      s2_start = 1'b0;
      if (t == 1) chk("araddr2_b0", {o2_arvalid, o2_araddr}, {1'b1, 32'h0000_0100});
      if (t == 2) chk("rready2_b0", o2_rready, 1);
      if (t == 3) chk("araddr2_b1", o2_araddr, 32'h0000_0104);
    end while (!o2_done && t < 20);
    chk("done2_b_latency", t, 5);
    chk("dvalid2_at_done", {o2_data_valid, o2_error, o2_arprot}, {1'b1, 1'b0, 3'b000});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
